nibble_byte_packer: RTL and testbench
=====================================

# nibble_byte_packer

Receive-side packer for the 4-bit `data` / 1-bit `en` stimulus interface. It samples a nibble on every clock where `in_en` is high and pairs consecutive nibbles into bytes. Completed bytes are buffered in a small FIFO and presented on a valid/ready output port. It sits directly behind any block or bench that drives the nibble interface, which has no backpressure. It converts that interface into a flow-controlled byte stream, with overflow detection and flush of a dangling half-byte.

## Interface
Parameters:
- `DEPTH`, default 4: number of FIFO entries; must be a power of 2 and at least 2.
- `LOW_FIRST`, default 1: 1 places the first nibble in `out_data[3:0]`; 0 places it in `out_data[7:4]`.

Ports:
- `clk`  in  1  the single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_data`  in  4  input nibble.
- `in_en`  in  1  nibble valid strobe; the nibble is always accepted.
- `flush`  in  1  single-cycle request to emit a held half-byte.
- `out_data`  out  8  head-of-FIFO byte.
- `out_partial`  out  1  high when the head byte came from a flush and holds only one nibble.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts the head byte when high together with `out_valid`.
- `fifo_count`  out  $clog2(DEPTH)+1  number of occupied FIFO entries.
- `overflow`  out  1  sticky flag: a byte was dropped.
- `clear_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- Pairing FSM has two states:
  - EMPTY: no nibble held.
  - HALF: one nibble held in `hold_reg`.
- Transitions per cycle:
  - EMPTY + `in_en`: the nibble goes to `hold_reg`; next state HALF.
  - HALF + `in_en`: the byte {hold, in} is formed and pushed, ordered per `LOW_FIRST`, with partial=0; next state EMPTY.
  - HALF + `flush` without `in_en`: the held nibble is pushed with the other nibble forced to 4'h0 and partial=1; next state EMPTY.
  - EMPTY + `flush` + `in_en`: the incoming nibble is pushed immediately as a partial byte; state stays EMPTY.
  - HALF + `flush` + `in_en`: a full byte is completed; `flush` has no further effect.
  - EMPTY + `flush` without `in_en`: no action.
- FIFO entries are 9 bits: {partial, byte}.
  - Output is show-ahead: `out_data` and `out_partial` always reflect the head entry.
  - Pop occurs when `out_valid && out_ready`.
- Full behaviour:
  - A push is accepted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
  - Otherwise the byte is dropped, `overflow` is set, and the FSM still advances as if the push had succeeded.
- `overflow` stays high until `clear_ovf`. If a new drop and `clear_ovf` occur in the same cycle, the flag remains set.
- `out_data` and `out_partial` are don't-care while `out_valid` is 0. The bench checks them only when valid.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. `fifo_count` increments on a push-only cycle, decrements on a pop-only cycle, and is unchanged when a push and pop occur together.

## Timing
- Reset values:
  - FSM EMPTY, `hold_reg` 0, pointers 0.
  - `fifo_count` 0, `out_valid` 0, `overflow` 0, `out_data` 8'h00, `out_partial` 0.
- Reset is asynchronous on assertion; deassertion is released by the clock edge. Reset mid-operation discards the held nibble and all FIFO contents, with no output glitch beyond the immediate clear.
- Latency:
  - A byte completed at edge N appears with `out_valid`=1 after edge N when the FIFO was empty, i.e. 1 cycle after the second nibble is sampled.
  - A flush push has the same 1-cycle latency.
- Pop takes effect at the edge where `out_valid && out_ready`. The next head is visible in the following cycle.
- Throughput: sustained `in_en`=1 yields one byte every 2 cycles. With `out_ready` held at 1, the FIFO never exceeds 1 entry.
- `flush`, `in_en` and `clear_ovf` are sampled only at rising edges; no combinational input-to-output paths exist.

## Test plan
- Reset, then `in_en` with nibbles 4'h5 and 4'hA on consecutive cycles, `out_ready`=1, `LOW_FIRST`=1 -> `out_data`=8'hA5, `out_partial`=0, `out_valid` high for exactly one cycle, one cycle after the second nibble.
- Single nibble 4'h3, then `flush` 3 cycles later -> `out_data`=8'h03, `out_partial`=1. A following `flush` with no nibble held produces no output.
- `out_ready`=0 with 2·(DEPTH+1) nibbles 0..9 (DEPTH=4) -> `fifo_count`=4 and `overflow`=1. Draining yields 8'h10, 8'h32, 8'h54, 8'h76; byte 8'h98 is lost. `clear_ovf` then returns `overflow` to 0.
- FIFO full with `out_ready`=1 on the same cycle a fifth byte completes -> no overflow, and `fifo_count` stays at 4.
- Assert `rst_n` low while in HALF with 3 bytes queued -> all outputs return to reset values immediately. After release, nibbles 4'hC, 4'hD give 8'hDC, proving the stale held nibble was discarded.
- EMPTY + `in_en`(4'hF) + `flush` in the same cycle -> `out_data`=8'h0F, `out_partial`=1. HALF(4'h1) + `in_en`(4'h2) + `flush` -> 8'h21, `out_partial`=0.

Source files
------------

// File: rtl/nibble_byte_packer.sv
// Nibble-to-byte packer: pairs strobed nibbles into bytes and queues them
// in a show-ahead FIFO behind a valid/ready port with sticky overflow.
module nibble_byte_packer #(
  parameter int DEPTH     = 4,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               in_data,
  input  logic                     in_en,
  input  logic                     flush,
  output logic [7:0]               out_data,
  output logic                     out_partial,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic {EMPTY, HALF} state_t;

  state_t        state_q, state_d;
  logic [3:0]    hold_q, hold_d;
  logic          push_req;
  logic [8:0]    push_ent;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          pop, push_ok, drop;

  function automatic logic [8:0] pack(
    input logic [3:0] first,
    input logic [3:0] second,
    input logic       part
  );
    return LOW_FIRST ? {part, second, first}
                     : {part, first, second};
  endfunction

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    push_req = 1'b0;
    push_ent = '0;
    unique case (state_q)
      EMPTY: begin
        if (in_en && flush) begin
          push_req = 1'b1;
          push_ent = pack(in_data, 4'h0, 1'b1);
        end else if (in_en) begin
          hold_d  = in_data;
          state_d = HALF;
        end
      end
      HALF: begin
        if (in_en) begin
          push_req = 1'b1;
          push_ent = pack(hold_q, in_data, 1'b0);
          state_d  = EMPTY;
        end else if (flush) begin
          push_req = 1'b1;
          push_ent = pack(hold_q, 4'h0, 1'b1);
          state_d  = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      hold_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // A full FIFO still accepts a push when the head leaves the same cycle.
  assign pop     = out_valid && out_ready;
  assign push_ok = push_req && ((count != CNT_FULL) || pop);
  assign drop    = push_req && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  assign out_valid   = (count != '0);
  assign fifo_count  = count;
  assign out_data    = out_valid ? mem[rptr][7:0] : 8'h00;
  assign out_partial = out_valid ? mem[rptr][8]   : 1'b0;

endmodule

// File: tb/tb_nibble_byte_packer.sv
// Scoreboard bench for nibble_byte_packer: directed cases plus random
// traffic checked against a queue-based reference of the pairing rules.
module tb_nibble_byte_packer;

  localparam int DEPTH     = 4;
  localparam bit LOW_FIRST = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_en, flush, out_ready, clear_ovf;
  logic [7:0] out_data;
  logic       out_partial, out_valid, overflow;
  logic [$clog2(DEPTH):0] fifo_count;

  int vecs = 0;
  int errs = 0;

  logic [3:0] nq[$];
  logic [8:0] mq[$];
  logic [8:0] sb[$];
  bit         ovf_m;

  nibble_byte_packer #(.DEPTH(DEPTH), .LOW_FIRST(LOW_FIRST)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_en(in_en),
    .flush(flush), .out_data(out_data), .out_partial(out_partial),
    .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow(overflow),
    .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] mk(input logic [3:0] f,
                                    input logic [3:0] s,
                                    input logic p);
    return LOW_FIRST ? {p, s, f} : {p, f, s};
  endfunction

  task automatic model_step(input logic en, input logic [3:0] d,
                            input logic fl, input logic rdy,
                            input logic clr);
    int sz;
    bit pop, push, drop;
    logic [8:0] v;
    sz = mq.size();
    pop = (sz > 0) && rdy;
    push = 0;
    drop = 0;
    v = '0;
    if (en) begin
      nq.push_back(d);
      if (nq.size() == 2) begin
        v = mk(nq[0], nq[1], 1'b0);
        push = 1;
        nq.delete();
      end else if (fl) begin
        v = mk(d, 4'h0, 1'b1);
        push = 1;
        nq.delete();
      end
    end else if (fl && nq.size() == 1) begin
      v = mk(nq[0], 4'h0, 1'b1);
      push = 1;
      nq.delete();
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) begin
        mq.push_back(v);
        sb.push_back(v);
      end else drop = 1;
    end
    if (drop) ovf_m = 1;
    else if (clr) ovf_m = 0;
  endtask

  task automatic cyc(input logic en, input logic [3:0] d,
                     input logic fl, input logic rdy,
                     input logic clr);
    in_en = en; in_data = d; flush = fl;
    out_ready = rdy; clear_ovf = clr;
    @(posedge clk);
    #1;
    model_step(en, d, fl, rdy, clr);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0, rdy, 1'b0);
  endtask

  task automatic check_reset_vals();
    chk("rst out_valid", out_valid, 0);
    chk("rst fifo_count", fifo_count, 0);
    chk("rst overflow", overflow, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_partial", out_partial, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (mq.size() > 0 && n < 40) begin
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    chk("drain timeout", mq.size(), 0);
  endtask

  // Monitor: compares head against the scoreboard on every accepted byte.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("out_valid", out_valid, mq.size() > 0);
      chk("fifo_count", fifo_count, mq.size());
      chk("overflow", overflow, ovf_m);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected byte", {out_partial, out_data}, -1);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("byte", {out_partial, out_data}, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_en = 0; in_data = 0; flush = 0; out_ready = 0; clear_ovf = 0;
    ovf_m = 0;
    #12;
    check_reset_vals();
    @(negedge clk);
    #1 rst_n = 1'b1;

    cyc(1, 4'h5, 0, 1, 0);
    cyc(1, 4'hA, 0, 1, 0);
    idle(3, 1);

    cyc(1, 4'h3, 0, 1, 0);
    idle(2, 1);
    cyc(0, 4'h0, 1, 1, 0);
    idle(2, 1);
    cyc(0, 4'h0, 1, 1, 0);
    idle(2, 1);

    for (int i = 0; i < 2 * (DEPTH + 1); i++)
      cyc(1, 4'(i), 0, 0, 0);
    idle(2, 0);
    drain();
    cyc(0, 4'h0, 0, 0, 1);
    idle(1, 0);

    for (int i = 0; i < 2 * DEPTH + 1; i++)
      cyc(1, 4'(i + 3), 0, 0, 0);
    cyc(1, 4'hE, 0, 1, 0);
    idle(1, 0);
    drain();

    for (int i = 0; i < 7; i++)
      cyc(1, 4'(i + 8), 0, 0, 0);
    in_en = 0; flush = 0; out_ready = 0; clear_ovf = 0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals();
    nq.delete(); mq.delete(); sb.delete(); ovf_m = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 4'hC, 0, 1, 0);
    cyc(1, 4'hD, 0, 1, 0);
    idle(2, 1);

    cyc(1, 4'hF, 1, 1, 0);
    idle(2, 1);
    cyc(1, 4'h1, 0, 1, 0);
    cyc(1, 4'h2, 1, 1, 0);
    idle(2, 1);

    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 9) < 7, 4'($urandom),
          $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 19) == 0);
    cyc(0, 4'h0, 1, 1, 1);
    drain();
    idle(2, 1);
    chk("scoreboard empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
